// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer in front of a single SRAM controller user interface.
// Grants one request at a time, holds the access for ACCESS_CYCLES and inserts a turnaround cycle on direction change.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int FIXED_PRIO    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [17:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic [1:0]  p0_be_n,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [17:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic [1:0]  p1_be_n,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic        ctl_read_en,
  output logic        ctl_wr_en,
  output logic [17:0] ctl_address,
  output logic [15:0] ctl_wr_data,
  output logic [1:0]  ctl_byte_en_n,
  input  logic [15:0] ctl_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TURN, ACCESS} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        last_dir;
  logic        gnt_port;
  logic        gnt_we;

  logic        q0;
  logic        q1;
  logic        win;
  logic        sel_we;
  logic [17:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_be_n;

  // A port whose ack is on the wire this cycle has already been served.
  assign q0 = p0_req & ~p0_ack;
  assign q1 = p1_req & ~p1_ack;

  always_comb begin
    if (FIXED_PRIO != 0)
      win = ~q0;
    else if (q0 & q1)
      win = ~last_grant;
    else
      win = q1;
    sel_we    = win ? p1_we    : p0_we;
    sel_addr  = win ? p1_addr  : p0_addr;
    sel_wdata = win ? p1_wdata : p0_wdata;
    sel_be_n  = win ? p1_be_n  : p0_be_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      last_dir      <= 1'b0;
      gnt_port      <= 1'b0;
      gnt_we        <= 1'b0;
      ctl_read_en   <= 1'b0;
      ctl_wr_en     <= 1'b0;
      ctl_address   <= '0;
      ctl_wr_data   <= '0;
      ctl_byte_en_n <= 2'b11;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
      busy          <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (q0 | q1) begin
            ctl_address   <= sel_addr;
            ctl_wr_data   <= sel_wdata;
            ctl_byte_en_n <= sel_be_n;
            gnt_port      <= win;
            gnt_we        <= sel_we;
            last_grant    <= win;
            cnt           <= '0;
            busy          <= 1'b1;
            if (sel_we != last_dir) begin
              state <= TURN;
            end else begin
              state       <= ACCESS;
              ctl_read_en <= ~sel_we;
              ctl_wr_en   <= sel_we;
            end
          end
        end
        TURN: begin
          state       <= ACCESS;
          ctl_read_en <= ~gnt_we;
          ctl_wr_en   <= gnt_we;
        end
        ACCESS: begin
          if (cnt == LAST_CNT) begin
            ctl_read_en <= 1'b0;
            ctl_wr_en   <= 1'b0;
            last_dir    <= gnt_we;
            busy        <= 1'b0;
            state       <= IDLE;
            if (gnt_port) p1_ack <= 1'b1;
            else          p0_ack <= 1'b1;
            if (!gnt_we && gnt_port)  p1_rdata <= ctl_read_data;
            if (!gnt_we && !gnt_port) p0_rdata <= ctl_read_data;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction table, contention and reset sequences, and a random phase,
// all cross-checked every cycle against a timeline-based reference model.
module tb_sram_arbiter;
  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic        we [2];
  logic [17:0] addr [2];
  logic [15:0] wdata [2];
  logic [1:0]  be_n [2];
  logic [1:0]  ack;
  logic [15:0] rdata [2];
  logic        ctl_read_en, ctl_wr_en, busy;
  logic [17:0] ctl_address;
  logic [15:0] ctl_wr_data, ctl_read_data;
  logic [1:0]  ctl_byte_en_n;

  logic        f_req [2];
  logic [1:0]  f_ack;
  logic [15:0] f_rdata [2];
  logic        f_rd, f_wr, f_busy;
  logic [17:0] f_addr;
  logic [15:0] f_wd;
  logic [1:0]  f_be;

  sram_arbiter #(.ACCESS_CYCLES(AC), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_be_n(be_n[0]),
    .p0_ack(ack[0]), .p0_rdata(rdata[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_be_n(be_n[1]),
    .p1_ack(ack[1]), .p1_rdata(rdata[1]),
    .ctl_read_en(ctl_read_en), .ctl_wr_en(ctl_wr_en), .ctl_address(ctl_address),
    .ctl_wr_data(ctl_wr_data), .ctl_byte_en_n(ctl_byte_en_n), .ctl_read_data(ctl_read_data),
    .busy(busy)
  );

  sram_arbiter #(.ACCESS_CYCLES(AC), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(f_req[0]), .p0_we(1'b0), .p0_addr(18'h00001), .p0_wdata(16'h0), .p0_be_n(2'b00),
    .p0_ack(f_ack[0]), .p0_rdata(f_rdata[0]),
    .p1_req(f_req[1]), .p1_we(1'b0), .p1_addr(18'h00002), .p1_wdata(16'h0), .p1_be_n(2'b00),
    .p1_ack(f_ack[1]), .p1_rdata(f_rdata[1]),
    .ctl_read_en(f_rd), .ctl_wr_en(f_wr), .ctl_address(f_addr),
    .ctl_wr_data(f_wd), .ctl_byte_en_n(f_be), .ctl_read_data(16'h5555),
    .busy(f_busy)
  );

  always #5 clk = ~clk;

  // SRAM behind the controller: byte-masked writes while wr_en, combinational read data.
  logic [15:0] sram [1024];
  logic        inited = 1'b0;
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 1024; i++) sram[i] <= (i == 16) ? 16'hBEEF : 16'hC3C3;
      inited <= 1'b1;
    end else if (ctl_wr_en) begin
      if (!ctl_byte_en_n[0]) sram[ctl_address[9:0]][7:0]  <= ctl_wr_data[7:0];
      if (!ctl_byte_en_n[1]) sram[ctl_address[9:0]][15:8] <= ctl_wr_data[15:8];
    end
  end
  assign ctl_read_data = sram[ctl_address[9:0]];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: each grant is a timeline of absolute cycle numbers.
  logic [15:0] shadow [1024];
  bit          m_active = 0, m_last_grant = 1, m_last_dir = 0, m_port = 0, m_we = 0;
  int          m_grant = 0, m_s_start = 0, m_s_end = 0, m_ack_at = 0, m_idle_from = 0;
  logic [17:0] m_addr = 0;
  logic [15:0] m_wdata = 0;
  logic [1:0]  m_be = 2'b11;
  bit          e_rd = 0, e_wr = 0, e_busy = 0;
  bit   [1:0]  e_ack = 0;
  logic [15:0] e_rdata [2] = '{16'h0, 16'h0};

  task automatic model_step();
    int n;
    bit q0, q1, w;
    n = cyc + 1;
    if (rst) begin
      m_active = 0; m_last_grant = 1; m_last_dir = 0; m_idle_from = n;
      m_port = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 2'b11;
      e_rdata[0] = 0; e_rdata[1] = 0;
    end else begin
      q0 = req[0] && !e_ack[0];
      q1 = req[1] && !e_ack[1];
      if (cyc >= m_idle_from && (q0 || q1)) begin
        w = (q0 && q1) ? !m_last_grant : q1;
        m_port = w; m_we = we[w]; m_addr = addr[w]; m_wdata = wdata[w]; m_be = be_n[w];
        m_grant = cyc;
        m_s_start = cyc + 1 + int'(m_we != m_last_dir);
        m_s_end = m_s_start + AC - 1;
        m_ack_at = m_s_end + 1;
        m_idle_from = m_ack_at;
        m_last_grant = w;
        m_active = 1;
      end
      if (m_active && cyc == m_s_end) begin
        m_last_dir = m_we;
        if (m_we) begin
          if (!m_be[0]) shadow[m_addr[9:0]][7:0]  = m_wdata[7:0];
          if (!m_be[1]) shadow[m_addr[9:0]][15:8] = m_wdata[15:8];
        end else begin
          e_rdata[m_port] = shadow[m_addr[9:0]];
        end
      end
    end
    e_rd     = m_active && !m_we && n >= m_s_start && n <= m_s_end;
    e_wr     = m_active &&  m_we && n >= m_s_start && n <= m_s_end;
    e_busy   = m_active && n > m_grant && n <= m_s_end;
    e_ack[0] = m_active && n == m_ack_at && !m_port;
    e_ack[1] = m_active && n == m_ack_at &&  m_port;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("read_en", ctl_read_en, e_rd);
    check("wr_en", ctl_wr_en, e_wr);
    check("address", ctl_address, m_addr);
    check("wr_data", ctl_wr_data, m_wdata);
    check("byte_en_n", ctl_byte_en_n, m_be);
    check("busy", busy, e_busy);
    check("ack", ack, e_ack);
    check("p0_rdata", rdata[0], e_rdata[0]);
    check("p1_rdata", rdata[1], e_rdata[1]);
    check("strobe_excl", ctl_read_en & ctl_wr_en, 1'b0);
  endtask

  task automatic new_req(input int p);
    req[p]   = 1'b1;
    we[p]    = 1'($urandom_range(0, 1));
    addr[p]  = 18'($urandom) & 18'h3000F;
    wdata[p] = 16'($urandom);
    be_n[p]  = 2'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req[0] = 0; req[1] = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          lat;
    logic [15:0] rd;
  } txn_t;

  txn_t tbl [6];
  int   ack_cyc [$];
  int   ack_port [$];

  initial begin
    tbl[0] = '{1, 1'b0, 18'h00010, 16'h0000, 2'b00, 3, 16'hBEEF};
    tbl[1] = '{0, 1'b1, 18'h00100, 16'hA5A5, 2'b00, 4, 16'h0000};
    tbl[2] = '{1, 1'b0, 18'h00100, 16'h0000, 2'b00, 4, 16'hA5A5};
    tbl[3] = '{0, 1'b1, 18'h00020, 16'h1234, 2'b10, 4, 16'h0000};
    tbl[4] = '{1, 1'b0, 18'h00020, 16'h0000, 2'b00, 4, 16'hC334};
    tbl[5] = '{0, 1'b0, 18'h00010, 16'h0000, 2'b11, 3, 16'hBEEF};

    for (int i = 0; i < 1024; i++) shadow[i] = (i == 16) ? 16'hBEEF : 16'hC3C3;
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; addr[p] = 0; wdata[p] = 0; be_n[p] = 2'b11; f_req[p] = 0;
    end

    do_reset();
    check("rst_byte_en_n", ctl_byte_en_n, 2'b11);
    check("rst_busy", busy, 1'b0);

    // Transaction table: one request at a time, latency measured to the ack.
    for (int i = 0; i < 6; i++) begin
      int n;
      int p;
      p = tbl[i].port;
      req[p] = 1; we[p] = tbl[i].we; addr[p] = tbl[i].addr;
      wdata[p] = tbl[i].wdata; be_n[p] = tbl[i].be;
      n = 0;
      do begin
        tick();
        n++;
      end while (!ack[p] && n < 20);
      check("txn_latency", n, tbl[i].lat);
      if (!tbl[i].we) check("txn_rdata", rdata[p], tbl[i].rd);
      req[p] = 0;
      tick();
    end

    // Round-robin contention: both ports read continuously from reset.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      req[p] = 1; we[p] = 0; addr[p] = 18'($urandom) & 18'h0000F;
    end
    for (int t = 1; t <= 15; t++) begin
      tick();
      for (int p = 0; p < 2; p++)
        if (ack[p]) begin
          ack_cyc.push_back(t);
          ack_port.push_back(p);
          addr[p] = 18'($urandom) & 18'h0000F;
        end
    end
    check("rr_ack_count", ack_cyc.size(), 5);
    for (int i = 0; i < ack_cyc.size(); i++) begin
      check("rr_ack_port", ack_port[i], i % 2);
      check("rr_ack_cycle", ack_cyc[i], 3 * (i + 1));
    end
    req[0] = 0; req[1] = 0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic, requests held until acked.
    for (int t = 0; t < 2000; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (e_ack[p]) req[p] = 0;
        if (!req[p] && $urandom_range(0, 2) == 0) new_req(p);
      end
      tick();
    end

    // Fixed priority: after a solo p0 access, a tie still goes to p0.
    req[0] = 0; req[1] = 0;
    begin
      int n;
      f_req[0] = 1;
      n = 0;
      do begin tick(); n++; end while (!f_ack[0] && n < 10);
      check("fp_solo_ack", f_ack, 2'b01);
      f_req[0] = 0;
      tick();
      tick();
      f_req[0] = 1; f_req[1] = 1;
      n = 0;
      do begin tick(); n++; end while (f_ack == 2'b00 && n < 10);
      check("fp_tie_winner", f_ack, 2'b01);
      f_req[0] = 0;
      n = 0;
      do begin tick(); n++; end while (!f_ack[1] && n < 10);
      check("fp_p1_after_drop", n, 3);
      f_req[1] = 0;
      tick();
    end

    // Reset in the first cycle of a write strobe aborts the access.
    for (int i = 0; i < 6; i++) tick();
    begin
      int n;
      req[0] = 1; we[0] = 1; addr[0] = 18'h00033; wdata[0] = 16'h7E7E; be_n[0] = 2'b00;
      n = 0;
      do begin tick(); n++; end while (!ctl_wr_en && n < 10);
      check("abort_wr_started", ctl_wr_en, 1'b1);
      rst = 1; req[0] = 0;
      tick();
      rst = 0;
      check("abort_wr_en", ctl_wr_en, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_address", ctl_address, 18'h0);
      check("abort_byte_en_n", ctl_byte_en_n, 2'b11);
      for (int i = 0; i < 5; i++) begin
        tick();
        check("abort_no_ack", ack[0], 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
